// File: rtl/riscv_definitions.sv
`default_nettype none
// ============================================================================
// Module   : riscv_definitions (package)
// Purpose  : Shared types and constants for the riscv-small pipeline:
//            register address, data bus, writeback FSM states, load funct3.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_definitions;

    // Architectural register index (x0..x31)
    typedef logic [4:0] regAddr_t;

    // 32-bit data bus, viewable as a word, two halves or four bytes.
    // halves[0] / bytes[0] are the least significant lanes.
    typedef union packed {
        logic [31:0]      word;
        logic [1:0][15:0] halves;
        logic [3:0][7:0]  bytes;
    } dataBus_u;

    // Memory/writeback stage FSM states
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wbState_t;

    // RV32I load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // True when a load of the given width cannot be served at this byte offset.
    // Reserved encodings (011/110/111) behave as LW and need word alignment.
    function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            LB, LBU: mis = 1'b0;
            LH, LHU: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load data alignment: selects the addressed byte or
//            halfword from a word-aligned read and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import riscv_definitions::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  dataBus_u   rdata,
    output dataBus_u   data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension according to the load type
    always_comb begin
        byte_sel = rdata.bytes[addr_lo];
        half_sel = rdata.halves[addr_lo[1]];
        data     = rdata;
        case (funct3)
            LB:      data.word = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data.word = {24'd0, byte_sel};
            LH:      data.word = {{16{half_sel[15]}}, half_sel};
            LHU:     data.word = {16'd0, half_sel};
            LW:      data.word = rdata.word;
            default: data.word = rdata.word;   // reserved codes act as LW
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory/writeback stage. Registers ALU results, completes loads
//            (wait for dmem response, align, extend), stalls upstream while a
//            load is outstanding, flags misaligned and timed-out loads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import riscv_definitions::*;
#(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       ex_valid,
    input  regAddr_t   ex_rd_addr,
    input  logic       ex_rd_wr_en,
    input  logic       ex_is_load,
    input  logic [2:0] ex_funct3,
    input  dataBus_u   ex_result,
    input  logic       dmem_rvalid,
    input  dataBus_u   dmem_rdata,
    output logic       stall,
    output regAddr_t   rd0_addr,
    output logic       rd0_wr_en,
    output dataBus_u   rd0_data,
    output logic       load_misalign,
    output logic       load_timeout
);

    // The wait counter only needs to reach LOAD_TIMEOUT-1, so it never wraps
    localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    wbState_t         state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    regAddr_t         ld_rd_q,      ld_rd_d;
    logic [2:0]       ld_funct3_q,  ld_funct3_d;
    logic [1:0]       ld_off_q,     ld_off_d;
    logic             ld_wen_q,     ld_wen_d;
    regAddr_t         rd0_addr_q,   rd0_addr_d;
    dataBus_u         rd0_data_q,   rd0_data_d;
    logic             rd0_wr_en_q,  rd0_wr_en_d;
    logic             misalign_q,   misalign_d;
    logic             timeout_q,    timeout_d;

    dataBus_u         aligned_data;

    load_align u_load_align (
        .funct3  (ld_funct3_q),
        .addr_lo (ld_off_q),
        .rdata   (dmem_rdata),
        .data    (aligned_data)
    );

    // Next-state logic: registered values hold, pulses default low
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        ld_wen_d    = ld_wen_q;
        rd0_addr_d  = rd0_addr_q;
        rd0_data_d  = rd0_data_q;
        rd0_wr_en_d = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // dmem_rvalid is deliberately not looked at here
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        rd0_addr_d  = ex_rd_addr;
                        rd0_data_d  = ex_result;
                        rd0_wr_en_d = ex_rd_wr_en && (ex_rd_addr != '0);
                    end else if (load_is_misaligned(ex_funct3, ex_result.word[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        ld_rd_d     = ex_rd_addr;
                        ld_funct3_d = ex_funct3;
                        ld_off_d    = ex_result.word[1:0];
                        ld_wen_d    = ex_rd_wr_en;
                        cnt_d       = '0;
                        state_d     = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                // ex_valid is ignored: upstream is holding its instruction
                if (dmem_rvalid) begin
                    rd0_addr_d  = ld_rd_q;
                    rd0_data_d  = aligned_data;
                    rd0_wr_en_d = ld_wen_q && (ld_rd_q != '0);
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything freezes while clk_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_off_q    <= '0;
            ld_wen_q    <= 1'b0;
            rd0_addr_q  <= '0;
            rd0_data_q  <= '0;
            rd0_wr_en_q <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            ld_wen_q    <= ld_wen_d;
            rd0_addr_q  <= rd0_addr_d;
            rd0_data_q  <= rd0_data_d;
            rd0_wr_en_q <= rd0_wr_en_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall         = (state_q == WAIT_LOAD);
    assign rd0_addr      = rd0_addr_q;
    assign rd0_data      = rd0_data_q;
    assign rd0_wr_en     = rd0_wr_en_q;
    assign load_misalign = misalign_q;
    assign load_timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage: directed vector table,
//            clock-enable and reset sequences, randomized transactions
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
    import riscv_definitions::*;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n, clk_en, ex_valid, ex_rd_wr_en, ex_is_load, dmem_rvalid;
    regAddr_t   ex_rd_addr, rd0_addr;
    logic [2:0] ex_funct3;
    dataBus_u   ex_result, dmem_rdata, rd0_data;
    logic       stall, rd0_wr_en, load_misalign, load_timeout;

    mem_wb_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .ex_valid      (ex_valid),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rd_wr_en   (ex_rd_wr_en),
        .ex_is_load    (ex_is_load),
        .ex_funct3     (ex_funct3),
        .ex_result     (ex_result),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .rd0_addr      (rd0_addr),
        .rd0_wr_en     (rd0_wr_en),
        .rd0_data      (rd0_data),
        .load_misalign (load_misalign),
        .load_timeout  (load_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model of the architecturally visible held outputs
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    typedef struct {
        bit          is_load;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wen;
        logic [31:0] addr;      // ALU result or load address
        logic [31:0] rdata;
        int          d;         // stall cycles incl. response cycle; > T = no response
        bit          exp_wr;
        logic [31:0] exp_data;
        bit          exp_mis;
        bit          exp_to;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Held outputs unchanged, no write, no stall
    task automatic chk_quiet(input string nm);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_wr"},    {31'd0, rd0_wr_en}, 32'd0);
        chk({nm, "_addr"},  {27'd0, rd0_addr}, {27'd0, m_addr});
        chk({nm, "_data"},  rd0_data.word, m_data);
    endtask

    // ---------------- reference model (arithmetic on the load rules) -------
    function automatic int ref_width(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % ref_width(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_value(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int unsigned off;
        logic [31:0] v;
        bit          sgn;
        sgn = (f3 == 3'b000 || f3 == 3'b001);
        off = addr % 4;
        case (ref_width(f3))
            1: begin
                v = (rdata >> (8 * off)) % 256;
                if (sgn && v >= 128) v = v - 32'd256;
            end
            2: begin
                v = (rdata >> (8 * (off - off % 2))) % 65536;
                if (sgn && v >= 32768) v = v - 32'd65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // ---------------- transaction drivers ---------------------------------
    task automatic run_alu(input string nm, input logic [4:0] rd, input bit wen,
                           input logic [31:0] result, input bit exp_wr);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_addr = rd; ex_rd_wr_en = wen;
        ex_funct3 = 3'($urandom); ex_result.word = result;
        @(negedge clk);
        ex_valid = 1'b0;
        m_addr = rd; m_data = result;
        chk({nm, "_wr"},    {31'd0, rd0_wr_en}, {31'd0, exp_wr});
        chk({nm, "_addr"},  {27'd0, rd0_addr}, {27'd0, rd});
        chk({nm, "_data"},  rd0_data.word, result);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk({nm, "_pulse_end"}, {31'd0, rd0_wr_en}, 32'd0);
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [4:0] rd,
                            input bit wen, input logic [31:0] addr, input logic [31:0] rdata,
                            input int d, input bit exp_mis, input bit exp_to,
                            input bit exp_wr, input logic [31:0] exp_data);
        int n;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = rd; ex_rd_wr_en = wen;
        ex_funct3 = f3; ex_result.word = addr;
        @(negedge clk);
        if (exp_mis) begin
            ex_valid = 1'b0;
            chk({nm, "_misalign"}, {31'd0, load_misalign}, 32'd1);
            chk_quiet({nm, "_mis"});
            @(negedge clk);
            chk({nm, "_mis_end"}, {31'd0, load_misalign}, 32'd0);
            chk({nm, "_mis_nostall"}, {31'd0, stall}, 32'd0);
            return;
        end
        n = exp_to ? T : d;
        for (int c = 0; c < n; c++) begin
            chk({nm, "_stall"}, {31'd0, stall}, 32'd1);
            chk({nm, "_nowr"},  {31'd0, rd0_wr_en}, 32'd0);
            // Unrelated instruction on the ex bus while stalled must be ignored
            ex_valid = 1'b1; ex_is_load = 1'($urandom); ex_rd_addr = 5'($urandom);
            ex_rd_wr_en = 1'b1; ex_funct3 = 3'($urandom); ex_result.word = $urandom;
            dmem_rvalid = (!exp_to && c == n - 1);
            dmem_rdata.word = dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
        end
        ex_valid = 1'b0; dmem_rvalid = 1'b0;
        if (exp_to) begin
            chk({nm, "_timeout"}, {31'd0, load_timeout}, 32'd1);
            chk_quiet({nm, "_to"});
            // Late response arriving in IDLE is spurious
            dmem_rvalid = 1'b1; dmem_rdata.word = $urandom;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            chk({nm, "_to_end"}, {31'd0, load_timeout}, 32'd0);
            chk_quiet({nm, "_late"});
        end else begin
            m_addr = rd; m_data = exp_data;
            chk({nm, "_wr"},    {31'd0, rd0_wr_en}, {31'd0, exp_wr});
            chk({nm, "_addr"},  {27'd0, rd0_addr}, {27'd0, rd});
            chk({nm, "_data"},  rd0_data.word, exp_data);
            chk({nm, "_stall_drop"}, {31'd0, stall}, 32'd0);
            chk({nm, "_no_to"}, {31'd0, load_timeout}, 32'd0);
            @(negedge clk);
            chk({nm, "_pulse_end"}, {31'd0, rd0_wr_en}, 32'd0);
        end
    endtask

    // ---------------- watchdog --------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 3'b000, 5,  1, 32'hDEADBEEF, 0,            0,     1, 32'hDEADBEEF, 0, 0};
        vecs[1]  = '{1, LB,     3,  1, 32'h00001002, 32'h00800000, 3,     1, 32'hFFFFFF80, 0, 0};
        vecs[2]  = '{1, LHU,    7,  1, 32'h00002002, 32'h80011234, 1,     1, 32'h00008001, 0, 0};
        vecs[3]  = '{1, LH,     7,  1, 32'h00002002, 32'h80011234, 2,     1, 32'hFFFF8001, 0, 0};
        vecs[4]  = '{1, LW,     4,  1, 32'h00001001, 32'h0,        1,     0, 32'h0,        1, 0};
        vecs[5]  = '{1, LW,     4,  1, 32'h00001000, 32'h0,        T + 1, 0, 32'h0,        0, 1};
        vecs[6]  = '{0, 3'b000, 0,  1, 32'h00001234, 0,            0,     0, 32'h00001234, 0, 0};
        vecs[7]  = '{1, LBU,    9,  1, 32'h00003003, 32'hAB000000, T,     1, 32'h000000AB, 0, 0};
        vecs[8]  = '{1, LH,     1,  1, 32'h00000001, 32'h0,        1,     0, 32'h0,        1, 0};
        vecs[9]  = '{1, 3'b011, 2,  1, 32'h00004000, 32'h12345678, 1,     1, 32'h12345678, 0, 0};
        vecs[10] = '{1, LW,     0,  1, 32'h00000010, 32'hCAFEF00D, 1,     0, 32'hCAFEF00D, 0, 0};
        vecs[11] = '{0, 3'b000, 6,  0, 32'h00000055, 0,            0,     0, 32'h00000055, 0, 0};
        vecs[12] = '{1, LB,     8,  1, 32'h00000001, 32'h00007F00, 2,     1, 32'h0000007F, 0, 0};
        vecs[13] = '{1, 3'b111, 12, 1, 32'h00000002, 32'h0,        1,     0, 32'h0,        1, 0};

        rst_n = 1'b0; clk_en = 1'b1; ex_valid = 1'b0; ex_rd_addr = '0; ex_rd_wr_en = 1'b0;
        ex_is_load = 1'b0; ex_funct3 = '0; ex_result = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_mis", {31'd0, load_misalign}, 32'd0);
        chk("reset_to",  {31'd0, load_timeout}, 32'd0);
        rst_n = 1'b1;
        // Spurious response in IDLE right after reset
        dmem_rvalid = 1'b1; dmem_rdata.word = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk_quiet("spurious");

        // ---------------- directed vector table ---------------------------
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].is_load)
                run_load(nm, vecs[i].f3, vecs[i].rd, vecs[i].wen, vecs[i].addr, vecs[i].rdata,
                         vecs[i].d, vecs[i].exp_mis, vecs[i].exp_to, vecs[i].exp_wr,
                         vecs[i].exp_data);
            else
                run_alu(nm, vecs[i].rd, vecs[i].wen, vecs[i].addr, vecs[i].exp_wr);
        end

        // ---------------- clock enable: ALU op and pulse hold -------------
        clk_en = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_addr = 5'd10; ex_rd_wr_en = 1'b1;
        ex_result.word = 32'h00000077;
        @(negedge clk);
        chk_quiet("ce_frozen");
        clk_en = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; clk_en = 1'b0;
        m_addr = 5'd10; m_data = 32'h77;
        chk("ce_wr", {31'd0, rd0_wr_en}, 32'd1);
        chk("ce_data", rd0_data.word, 32'h77);
        @(negedge clk);
        chk("ce_pulse_hold", {31'd0, rd0_wr_en}, 32'd1);
        clk_en = 1'b1;
        @(negedge clk);
        chk("ce_pulse_drop", {31'd0, rd0_wr_en}, 32'd0);

        // ---------------- clock enable: held response during load ---------
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd11; ex_rd_wr_en = 1'b1;
        ex_funct3 = LBU; ex_result.word = 32'h00000001;
        @(negedge clk);
        ex_valid = 1'b0; clk_en = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata.word = 32'h0000C300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ce_ld_stall", {31'd0, stall}, 32'd1);
            chk("ce_ld_nowr", {31'd0, rd0_wr_en}, 32'd0);
        end
        clk_en = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        m_addr = 5'd11; m_data = 32'h000000C3;
        chk("ce_ld_wr", {31'd0, rd0_wr_en}, 32'd1);
        chk("ce_ld_data", rd0_data.word, 32'h000000C3);
        chk("ce_ld_stall_drop", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // ---------------- asynchronous reset mid-load ---------------------
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd4; ex_rd_wr_en = 1'b1;
        ex_funct3 = LW; ex_result.word = 32'h00000100;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rst_ld_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_addr = '0; m_data = '0;
        chk_quiet("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata.word = 32'h5A5A5A5A;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk_quiet("rst_discard");

        // ---------------- randomized transactions vs. model ---------------
        for (int k = 0; k < 60; k++) begin
            logic [2:0]  f3;
            logic [4:0]  rd;
            bit          wen, mis, to;
            logic [31:0] a, rdat;
            int          d;
            string       nm;
            nm   = $sformatf("rnd%0d", k);
            f3   = 3'($urandom);
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            wen  = ($urandom_range(0, 4) != 0);
            a    = $urandom;
            rdat = $urandom;
            d    = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(1, 4);
            if ($urandom_range(0, 2) == 0) begin
                run_alu(nm, rd, wen, a, wen && rd != 0);
            end else begin
                mis = ref_misaligned(f3, a);
                to  = !mis && d > T;
                run_load(nm, f3, rd, wen, a, rdat, d, mis, to,
                         !mis && !to && wen && rd != 0, ref_value(f3, a, rdat));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage of the riscv-small pipeline, sitting directly upstream of `reg_file` and driving its `rd0_addr`/`rd0_wr_en`/`rd0_data` write port. It registers ALU results from the execute stage and completes loads. For each load it waits for the data-memory response, then aligns and sign- or zero-extends the returned word. While a load is outstanding it stalls the upstream pipeline, and it reports misaligned and timed-out loads.

## Interface
Parameters:
- `LOAD_TIMEOUT`, 16: maximum cycles spent in WAIT_LOAD before abort; must be ≥ 2.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `clk_en`  in  1  clock enable; all state frozen when low
- `ex_valid`  in  1  execute stage presents an instruction this cycle
- `ex_rd_addr`  in  regAddr_t  destination register
- `ex_rd_wr_en`  in  1  instruction writes rd
- `ex_is_load`  in  1  instruction is a load; `ex_result` is then the byte address
- `ex_funct3`  in  3  load width/sign (RV32I encoding)
- `ex_result`  in  dataBus_u  ALU result or load address
- `dmem_rvalid`  in  1  data-memory read response valid
- `dmem_rdata`  in  dataBus_u  data-memory read word (word-aligned)
- `stall`  out  1  upstream must hold its instruction
- `rd0_addr`  out  regAddr_t  to `reg_file`
- `rd0_wr_en`  out  1  to `reg_file`; one-cycle pulse
- `rd0_data`  out  dataBus_u  to `reg_file`
- `load_misalign`  out  1  one-cycle pulse: misaligned load dropped
- `load_timeout`  out  1  one-cycle pulse: load aborted after LOAD_TIMEOUT cycles

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. All transitions and registered updates occur only on a `clk` edge with `clk_en`=1.
- `stall` = (state == WAIT_LOAD). It is combinational from state only.
- In IDLE with `ex_valid`=1 and `ex_is_load`=0:
  - register `rd0_addr`←`ex_rd_addr` and `rd0_data`←`ex_result`.
  - `rd0_wr_en`←`ex_rd_wr_en` && (`ex_rd_addr`≠0).
- In IDLE with `ex_valid`=1 and `ex_is_load`=1, check alignment first:
  - Halfword (001/101) requires addr[0]=0. Word (010 and the reserved codes 011/110/111, all treated as LW) requires addr[1:0]=00. Bytes are always aligned.
  - Misaligned: pulse `load_misalign`, no write, stay IDLE.
  - Aligned: latch rd, funct3, addr[1:0] and the rd write enable; clear the timeout counter; go to WAIT_LOAD.
- In WAIT_LOAD with `dmem_rvalid`=1:
  - Byte = `dmem_rdata[8*addr[1:0] +: 8]`; half = `dmem_rdata[16*addr[1] +: 16]`.
  - 000 sign-extends the byte, 100 zero-extends the byte, 001 sign-extends the half, 101 zero-extends the half, 010 passes the word.
  - Register the extended value into `rd0_data`, pulse `rd0_wr_en` if rd≠0 and the write enable was set, then return to IDLE.
- In WAIT_LOAD without `rdvalid`: increment the counter. When the counter reaches LOAD_TIMEOUT-1, pulse `load_timeout`, perform no write, and return to IDLE.
- Ignored inputs:
  - `ex_valid` while in WAIT_LOAD (upstream is holding).
  - `dmem_rvalid` while in IDLE (spurious response).
- A write to x0 is never issued. `rd0_wr_en` is never asserted with `rd0_addr`=0.

## Timing
- Reset values: state IDLE, `rd0_addr`=0, `rd0_data`=0, `rd0_wr_en`=0, `load_misalign`=0, `load_timeout`=0, counter 0, `stall`=0.
- Reset mid-load discards the load. No write follows.
- Non-load latency: the write pulse appears 1 cycle after capture.
- Load latency: 1 cycle after the `dmem_rvalid` edge. `stall` rises the cycle after capture and falls in the same cycle the write pulse appears.
- `rd0_addr` and `rd0_data` hold their value between updates. `rd0_wr_en` and the error flags are single-cycle pulses.
- With `clk_en`=0, outputs hold except the pulses, which drop to 0 after the next enabled edge only. The memory must hold `dmem_rvalid` until it is sampled with `clk_en`=1.
- The counter is `$clog2(LOAD_TIMEOUT)` bits wide and does not wrap, because it exits at LOAD_TIMEOUT-1.

## Structure
- `riscv_definitions` package: add `wbState_t` enum {IDLE, WAIT_LOAD} and `loadFunct3_t` constants (LB, LH, LW, LBU, LHU). `dataBus_u` and `regAddr_t` already live there.
- One sub-module: `load_align`, purely combinational (funct3, addr[1:0], rdata → extended data). It is reused by store/debug paths later.

## Test plan
- ALU op, rd=5, result 0xDEADBEEF → next cycle `rd0_wr_en`=1, `rd0_addr`=5, `rd0_data`=0xDEADBEEF; pulse lasts exactly 1 cycle.
- LB rd=3, addr 0x1002; `rdata`=0x00800000 after 3 cycles → `stall` high 3 cycles, then write 0xFFFFFF80 to x3.
- LHU rd=7, addr 0x2002, `rdata`=0x8001_1234 → write 0x00008001; LH at the same address → 0xFFFF8001.
- LW at addr 0x1001 → `load_misalign` pulse, no `rd0_wr_en`, `stall` never asserted.
- LW rd=4 with no response, LOAD_TIMEOUT=16 → `load_timeout` pulse after 16 cycles in WAIT_LOAD, no write, `stall` drops. A later `dmem_rvalid` is ignored.
- ALU op with rd=0, result 0x1234 → `rd0_wr_en` stays 0. Separately, `rst_n` low mid-load → all outputs return to reset values and no write occurs.
